// File: rtl/ifetch_stage_if.sv
// Instruction-memory fetch bus between ifetch_stage and the instruction memory.
//   imem_req    fetch request, one outstanding at a time (driven by the fetch stage)
//   imem_addr   word-aligned fetch address (driven by the fetch stage)
//   imem_rvalid read data valid, only meaningful while imem_req=1 (driven by memory)
//   imem_rdata  instruction word (driven by memory)
// master modport: fetch stage side. slave modport: memory side.
interface ifetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/ifetch_stage.sv
// Instruction-fetch stage feeding the decoder.
// Holds the PC, fetches one instruction at a time over a req/rvalid handshake so
// the instruction memory may have any latency, presents the latched instruction to
// decode, and moves to the next PC (selected by the decoder's npc_op) on retire.
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   imem          fetch bus (master side): imem_req, imem_addr, imem_rvalid, imem_rdata
//   instr         latched instruction ([31:26]=Op, [5:0]=Funct)
//   instr_valid   instr/pc valid for decode/execute
//   pc, pc_plus4  address of instr and its +4 link value
//   npc_op        00 +4, 01 branch, 10 jump imm26, 11 jump register
//   jr_target     register target for npc_op=11
//   retire, stall instruction consumed (ignored while stall=1)
//   addr_err      one-cycle pulse for a misaligned register jump that retired
//   retired_cnt   retired instruction count, wraps modulo 2^32
// Parameters:
//   RESET_PC      PC loaded on reset
//   RESET_CNT     retired_cnt value loaded on reset (0 in normal use; a nonzero
//                 value lets the counter wrap be exercised quickly)
module ifetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] RESET_CNT = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  ifetch_stage_if.master        imem,
  output logic [31:0]           instr,
  output logic                  instr_valid,
  output logic [31:0]           pc,
  output logic [31:0]           pc_plus4,
  input  logic [1:0]            npc_op,
  input  logic [31:0]           jr_target,
  input  logic                  retire,
  input  logic                  stall,
  output logic                  addr_err,
  output logic [31:0]           retired_cnt
);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    VALID = 1'b1
  } state_t;

  state_t      state_r;
  logic        fire_s;
  logic        misaligned_s;
  logic [31:0] npc_s;

  // Sign-extended, word-scaled branch displacement from the 16-bit immediate.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

  assign pc_plus4     = pc + 32'd4;
  assign fire_s       = (state_r == VALID) && retire && !stall;
  assign misaligned_s = (jr_target[1:0] != 2'b00);

  // The request is gated by rst so it drops the instant reset is asserted,
  // even before the asynchronous state change settles.
  assign imem.imem_req  = (state_r == FETCH) && !rst;
  assign imem.imem_addr = pc;
  assign instr_valid    = (state_r == VALID);

  // Next-PC selection from the latched instruction and decoder control.
  always_comb begin
    npc_s = pc_plus4;
    case (npc_op)
      2'b00:   npc_s = pc_plus4;
      2'b01:   npc_s = pc_plus4 + branch_offset(instr[15:0]);
      2'b10:   npc_s = {pc_plus4[31:28], instr[25:0], 2'b00};
      2'b11:   npc_s = {jr_target[31:2], 2'b00};
      default: npc_s = pc_plus4;
    endcase
  end

  // Fetch/valid state machine with PC, instruction, counter and error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= FETCH;
      pc          <= RESET_PC;
      instr       <= 32'h0000_0000;
      addr_err    <= 1'b0;
      retired_cnt <= RESET_CNT;
    end else begin
      addr_err <= 1'b0;
      case (state_r)
        FETCH: begin
          if (imem.imem_rvalid) begin
            instr   <= imem.imem_rdata;
            state_r <= VALID;
          end else begin
            state_r <= FETCH;
          end
        end
        VALID: begin
          // rvalid is ignored here: no request is outstanding.
          if (fire_s) begin
            pc          <= npc_s;
            retired_cnt <= retired_cnt + 32'd1;
            addr_err    <= (npc_op == 2'b11) && misaligned_s;
            state_r     <= FETCH;
          end else begin
            state_r <= VALID;
          end
        end
        default: state_r <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_stage.sv
// Self-checking bench for ifetch_stage: stimulus pushes expected fetch addresses,
// instructions and retire results into queues; a negedge monitor pops and compares.
module tb_ifetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  ifetch_stage_if bus ();
  ifetch_stage_if wbus ();

  logic [31:0] instr, pc, pc_plus4, retired_cnt, jr_target;
  logic        instr_valid, addr_err, retire, stall;
  logic [1:0]  npc_op;

  logic [31:0] w_instr, w_pc, w_pc_plus4, w_cnt;
  logic        w_valid, w_err, w_retire;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_instr[$];
  logic [31:0] exp_ipc[$];
  logic [31:0] exp_npc[$];
  logic [31:0] exp_cnt[$];
  logic        exp_err[$];

  always #5 clk = ~clk;

  ifetch_stage #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .rst(rst), .imem(bus.master),
    .instr(instr), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .npc_op(npc_op), .jr_target(jr_target), .retire(retire), .stall(stall),
    .addr_err(addr_err), .retired_cnt(retired_cnt)
  );

  // Second instance: zero-wait memory, counter preset just below wrap.
  assign wbus.imem_rvalid = 1'b1;
  assign wbus.imem_rdata  = 32'h0000_0000;

  ifetch_stage #(.RESET_PC(32'h0000_0000), .RESET_CNT(32'hFFFF_FFFF)) u_wrap (
    .clk(clk), .rst(rst), .imem(wbus.master),
    .instr(w_instr), .instr_valid(w_valid), .pc(w_pc), .pc_plus4(w_pc_plus4),
    .npc_op(2'b00), .jr_target(32'h0000_0000), .retire(w_retire), .stall(1'b0),
    .addr_err(w_err), .retired_cnt(w_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural next-PC rule, written with plain arithmetic.
  function automatic logic [31:0] model_npc(input logic [31:0] cur, input logic [31:0] w,
                                            input logic [1:0] op, input logic [31:0] jt);
    logic [31:0] seq;
    int          disp;
    seq = cur + 32'd4;
    case (op)
      2'd0: return seq;
      2'd1: begin
        disp = int'($signed(w[15:0]));
        return seq + 32'(disp * 4);
      end
      2'd2: return (seq & 32'hF000_0000) | (32'(w[25:0]) << 2);
      default: return jt & 32'hFFFF_FFFC;
    endcase
  endfunction

  // One instruction: memory latency, optional stalled-retire cycles, then retire.
  task automatic do_instr(input logic [31:0] w, input int lat, input int stalls,
                          input logic [1:0] op, input logic [31:0] jt);
    logic [31:0] npc;
    exp_instr.push_back(w);
    exp_ipc.push_back(m_pc);
    for (int i = 0; i < lat; i++) begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom;
      retire          = 1'($urandom);
      stall           = 1'($urandom);
      npc_op          = 2'($urandom);
      jr_target       = $urandom;
      @(posedge clk); #1;
    end
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = w;
    retire          = 1'b0;
    stall           = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < stalls; i++) begin
      bus.imem_rvalid = 1'($urandom);
      bus.imem_rdata  = $urandom;
      retire          = 1'b1;
      stall           = 1'b1;
      npc_op          = 2'b11;
      jr_target       = 32'h0000_0003;
      @(posedge clk); #1;
    end
    bus.imem_rvalid = 1'($urandom);
    bus.imem_rdata  = $urandom;
    npc   = model_npc(m_pc, w, op, jt);
    m_cnt = m_cnt + 32'd1;
    exp_err.push_back((op == 2'b11) && (jt[1:0] != 2'b00));
    exp_cnt.push_back(m_cnt);
    exp_npc.push_back(npc);
    exp_addr.push_back(npc);
    m_pc      = npc;
    retire    = 1'b1;
    stall     = 1'b0;
    npc_op    = op;
    jr_target = jt;
    @(posedge clk); #1;
    bus.imem_rvalid = 1'b0;
    retire          = 1'b0;
    stall           = 1'b0;
  endtask

  // Monitor state.
  logic        prev_req, prev_valid, pend;
  logic [31:0] held_addr, held_instr, held_pc, held_cnt, e_word;

  // Monitor: pops expectations when the DUT presents a request, an instruction or a retire result.
  always @(negedge clk) begin
    if (rst) begin
      prev_req   = 1'b0;
      prev_valid = 1'b0;
      pend       = 1'b0;
    end else begin
      if (pend) begin
        if (exp_npc.size() == 0) begin
          check("retire_expected", 32'd1, 32'd0);
        end else begin
          check("addr_err", 32'(addr_err), 32'(exp_err.pop_front()));
          check("retired_cnt", retired_cnt, exp_cnt.pop_front());
          check("next_pc", pc, exp_npc.pop_front());
        end
      end else begin
        check("addr_err_idle", 32'(addr_err), 32'd0);
      end
      check("req_vs_valid", 32'(bus.imem_req), 32'(!instr_valid));
      if (bus.imem_req && !prev_req) begin
        if (exp_addr.size() == 0) check("fetch_expected", 32'd1, 32'd0);
        else check("fetch_addr", bus.imem_addr, exp_addr.pop_front());
      end else if (bus.imem_req) begin
        check("addr_stable", bus.imem_addr, held_addr);
      end
      if (instr_valid && !prev_valid) begin
        if (exp_instr.size() == 0) begin
          check("instr_expected", 32'd1, 32'd0);
        end else begin
          check("instr", instr, exp_instr.pop_front());
          e_word = exp_ipc.pop_front();
          check("instr_pc", pc, e_word);
          check("pc_plus4", pc_plus4, e_word + 32'd4);
        end
      end else if (instr_valid) begin
        check("instr_hold", instr, held_instr);
        check("pc_hold", pc, held_pc);
        check("cnt_hold", retired_cnt, held_cnt);
      end
      pend       = instr_valid && retire && !stall;
      prev_req   = bus.imem_req;
      prev_valid = instr_valid;
      held_addr  = bus.imem_addr;
      held_instr = instr;
      held_pc    = pc;
      held_cnt   = retired_cnt;
    end
  end

  task automatic check_reset_values();
    check("rst_pc", pc, 32'h0000_3000);
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_cnt", retired_cnt, 32'd0);
    check("rst_err", 32'(addr_err), 32'd0);
  endtask

  initial begin
    bus.imem_rvalid = 1'b1;  // spurious while reset is held
    bus.imem_rdata  = 32'hDEAD_BEEF;
    retire = 1'b0; stall = 1'b0; npc_op = 2'b00; jr_target = 32'h0000_0000;
    w_retire = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_reset_values();
    check("rst_instr", instr, 32'h0000_0000);
    bus.imem_rvalid = 1'b0;
    m_pc  = 32'h0000_3000;
    m_cnt = 32'd0;
    exp_addr.push_back(m_pc);
    rst = 1'b0;

    // Sequential, zero-wait, retire every valid cycle.
    for (int i = 0; i < 4; i++) do_instr($urandom, 0, 0, 2'b00, 32'h0);
    // Branch back and absolute jump (pc 0x3010 -> 0x300C -> 0x3000).
    do_instr(32'h1000_FFFE, 0, 0, 2'b01, 32'h0);
    do_instr(32'h0800_0C00, 1, 0, 2'b10, 32'h0);
    // Register jumps, misaligned then aligned; latency 3 and two stalled retires.
    do_instr($urandom, 2, 0, 2'b11, 32'h0000_3021);
    do_instr($urandom, 3, 2, 2'b11, 32'h0000_3040);
    // PC wrap at the top of the address space.
    do_instr($urandom, 0, 0, 2'b11, 32'hFFFF_FFFC);
    do_instr($urandom, 1, 1, 2'b00, 32'h0);
    // Randomized mix of all next-PC kinds, latencies and stalls.
    for (int i = 0; i < 40; i++)
      do_instr($urandom, $urandom_range(0, 3), $urandom_range(0, 2), 2'($urandom), $urandom);

    // Reset in the middle of an outstanding fetch, with a response arriving.
    @(posedge clk); #1;
    rst = 1'b1;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hCAFE_F00D;
    #1;
    check_reset_values();
    @(posedge clk); #1;
    bus.imem_rvalid = 1'b0;
    m_pc  = 32'h0000_3000;
    m_cnt = 32'd0;
    exp_addr.push_back(m_pc);
    rst = 1'b0;
    for (int i = 0; i < 6; i++)
      do_instr($urandom, $urandom_range(0, 2), $urandom_range(0, 1), 2'($urandom), $urandom);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Retired counter wrap on the preset instance.
    check("wrap_valid", 32'(w_valid), 32'd1);
    check("wrap_cnt_pre", w_cnt, 32'hFFFF_FFFF);
    w_retire = 1'b1;
    @(posedge clk); #1;
    w_retire = 1'b0;
    check("wrap_cnt", w_cnt, 32'd0);
    check("wrap_pc", w_pc, 32'h0000_0004);

    check("queues_drained", 32'(exp_addr.size() + exp_instr.size() + exp_npc.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
